// File: rtl/cpu_pkg.sv
// Shared definitions for the boot sequencer: FSM state encodings and default widths.
package cpu_pkg;

  localparam int DEF_ADD_WIDTH  = 7;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CYC_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } boot_state_e;

endpackage

// File: rtl/boot_addr_counter.sv
// Program-load byte counter: write address plus remaining-bytes count with a last-byte flag.
module boot_addr_counter
  import cpu_pkg::*;
#(
  parameter int ADD_WIDTH = DEF_ADD_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [ADD_WIDTH:0]   i_len,
  input  logic                 i_advance,
  output logic [ADD_WIDTH-1:0] o_addr,
  output logic                 o_last
);

  localparam logic [ADD_WIDTH:0] FULL_LEN = {1'b1, {ADD_WIDTH{1'b0}}};

  logic [ADD_WIDTH-1:0] r_addr;
  logic [ADD_WIDTH:0]   r_remaining;

  // A zero length means a full-depth load; remaining never underflows, so the
  // address cannot run past the top of program memory within one load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_start) begin
      r_addr      <= '0;
      r_remaining <= (i_len == '0) ? FULL_LEN : i_len;
    end else if (i_advance && (r_remaining != '0)) begin
      r_addr      <= r_addr + ADD_WIDTH'(1);
      r_remaining <= r_remaining - (ADD_WIDTH+1)'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remaining == (ADD_WIDTH+1)'(1));

endmodule

// File: rtl/cpu_boot_sequencer.sv
// Boot sequencer for the RISC-V core: loads program bytes, then runs the core for a bounded
// or free-running number of cycles. Define BOOT_CHECKSUM_EN to add the XOR checksum output.
module cpu_boot_sequencer
  import cpu_pkg::*;
#(
  parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CYC_WIDTH  = DEF_CYC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [ADD_WIDTH:0]    load_len,
  input  logic                  run_start,
  input  logic [CYC_WIDTH-1:0]  run_cycles,
  input  logic                  halt,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  pm_wr_en,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [DATA_WIDTH-1:0] pm_wdata,
  output logic                  cpu_rst,
  output logic [1:0]            state,
  output logic                  loaded,
  output logic                  done,
  output logic [CYC_WIDTH-1:0]  cycle_count
`ifdef BOOT_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  localparam logic [CYC_WIDTH-1:0] CYC_MAX = '1;

  boot_state_e r_state;
  boot_state_e w_next_state;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_load_go;
  logic                  w_run_go;
  logic                  w_load_fin;
  logic                  w_budget_hit;
  logic [ADD_WIDTH-1:0]  w_addr;

  logic                  r_pm_wr_en;
  logic [ADD_WIDTH-1:0]  r_pm_addr;
  logic [DATA_WIDTH-1:0] r_pm_wdata;
  logic                  r_loaded;
  logic                  r_load_done;
  logic [CYC_WIDTH-1:0]  r_cycle_count;
  logic [CYC_WIDTH-1:0]  r_run_budget;

  // Commands are only honoured in IDLE, and halt outranks both of them there.
  assign w_accept     = in_valid && (r_state == ST_LOAD);
  assign w_load_go    = (r_state == ST_IDLE) && !halt && load_start;
  assign w_run_go     = (r_state == ST_IDLE) && !halt && !load_start && run_start && r_loaded;
  assign w_load_fin   = w_accept && w_last && !halt;
  assign w_budget_hit = (r_run_budget != '0) &&
                        (r_cycle_count == r_run_budget - CYC_WIDTH'(1));

  boot_addr_counter #(
    .ADD_WIDTH (ADD_WIDTH)
  ) u_addr_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_load_go),
    .i_len     (load_len),
    .i_advance (w_accept),
    .o_addr    (w_addr),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block purely combinational (no latch).
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_load_go)     w_next_state = ST_LOAD;
        else if (w_run_go) w_next_state = ST_RUN;
      end
      ST_LOAD: begin
        if (halt)            w_next_state = ST_STOP;
        else if (w_load_fin) w_next_state = ST_IDLE;
      end
      ST_RUN: begin
        if (halt || w_budget_hit) w_next_state = ST_STOP;
      end
      ST_STOP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == ST_LOAD);
    cpu_rst  = (r_state != ST_RUN);
    done     = (r_state == ST_STOP) || r_load_done;
    state    = r_state;
  end

  // NOTE: non-blocking assignments so every register here samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pm_wr_en    <= 1'b0;
      r_pm_addr     <= '0;
      r_pm_wdata    <= '0;
      r_loaded      <= 1'b0;
      r_load_done   <= 1'b0;
      r_cycle_count <= '0;
      r_run_budget  <= '0;
    end else begin
      r_pm_wr_en  <= w_accept;
      r_load_done <= w_load_fin;
      if (w_accept) begin
        r_pm_addr  <= w_addr;
        r_pm_wdata <= in_data;
      end
      if (w_load_go)       r_loaded <= 1'b0;
      else if (w_load_fin) r_loaded <= 1'b1;
      // The count is held through STOP and IDLE so the last run length stays visible.
      if (w_run_go) begin
        r_cycle_count <= '0;
        r_run_budget  <= run_cycles;
      end else if ((r_state == ST_RUN) && (r_cycle_count != CYC_MAX)) begin
        r_cycle_count <= r_cycle_count + CYC_WIDTH'(1);
      end
    end
  end

  assign pm_wr_en    = r_pm_wr_en;
  assign pm_addr     = r_pm_addr;
  assign pm_wdata    = r_pm_wdata;
  assign loaded      = r_loaded;
  assign cycle_count = r_cycle_count;

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_checksum <= '0;
    else if (w_load_go) r_checksum <= '0;
    else if (w_accept)  r_checksum <= r_checksum ^ in_data;
  end

  assign checksum = r_checksum;
`else
  // Default build carries no checksum state.
`endif

endmodule
